// File: rtl/kgp_pc_seq_pkg.sv
// kgp_pc_seq_pkg: shared state, opcode and branch-control definitions for pc_sequencer
package kgp_pc_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_FAULT} state_t;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 29;
  localparam int FUNC_MSB = 28;
  localparam int FUNC_LSB = 26;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_ILLEGAL = 2'b01;
  localparam logic [2:0] OPC_BR_REG = 3'b100;
  localparam logic [2:0] OPC_BR_FLAG = 3'b101;
  localparam logic [2:0] OPC_BL = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam logic [1:0] BR_REG = 2'b00;
  localparam logic [1:0] BR_FLAG = 2'b01;
  localparam logic [1:0] BR_LINK = 2'b10;
  localparam logic [1:0] BR_NONE = 2'b11;
  function automatic logic [1:0] br_ctrl_of(input logic [2:0] opc);
    return opc == OPC_BR_REG ? BR_REG : opc == OPC_BR_FLAG ? BR_FLAG : opc == OPC_BL ? BR_LINK : BR_NONE;
  endfunction
endpackage

// File: rtl/pc_sequencer_fetch_watchdog.sv
// fetch_watchdog: counts consecutive ack-less FETCH cycles and flags the limit cycle
module fetch_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expire = en && cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle KGP-RISC sequencer owning PC; fetch watchdog under PC_SEQ_FETCH_TIMEOUT_EN
module pc_sequencer
  import kgp_pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        alu_start,
  input  logic        alu_valid,
  input  logic [2:0]  alu_flags,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  output logic [1:0]  br_ctrl,
  output logic [5:0]  br_func,
  output logic [31:0] br_dest,
  output logic [2:0]  br_flags,
  output logic        lr_we,
  output logic [31:0] lr_wdata,
  output logic        busy,
  output logic        halted,
  output logic        fault
);
  state_t state;
  logic [31:0] instr_q;
  logic [2:0] flags_q;
  logic alu_start_q;
  logic wdt_expire;
  logic [2:0] opc;
  assign opc = instr_q[OPC_MSB:OPC_LSB];
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
  fetch_watchdog #(.LIMIT(FETCH_TIMEOUT)) u_wdt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != S_FETCH),
    .en(state == S_FETCH && !imem_ack),
    .expire(wdt_expire)
  );
`else
  // without the watchdog FETCH never expires; the limit is only referenced
  assign wdt_expire = FETCH_TIMEOUT < 0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      instr_q <= '0;
      flags_q <= '0;
      alu_start_q <= 1'b0;
    end else begin
      alu_start_q <= state == S_DECODE && opc[2:1] == CLS_ALU;
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH:
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state <= S_DECODE;
          end else if (wdt_expire) state <= S_FAULT;
        S_DECODE:
          state <= opc[2:1] == CLS_ALU ? S_EXEC : opc[2:1] == CLS_ILLEGAL ? S_FAULT :
                   opc == OPC_HALT ? S_HALT : S_UPDATE;
        S_EXEC:
          if (alu_valid) begin
            flags_q <= alu_flags;
            state <= S_UPDATE;
          end
        S_UPDATE: begin
          pc <= pc_next;
          state <= S_FETCH;
        end
        S_HALT:
          if (start) begin
            pc <= pc + 32'd1;
            state <= S_FETCH;
          end
        default: ;
      endcase
    end
  assign imem_req = state == S_FETCH;
  assign imem_addr = pc;
  assign alu_start = alu_start_q;
  assign br_ctrl = (state == S_DECODE || state == S_UPDATE) ? br_ctrl_of(opc) : BR_NONE;
  assign br_func = {3'b000, instr_q[FUNC_MSB:FUNC_LSB]};
  assign br_dest = {6'b0, instr_q[TGT_MSB:TGT_LSB]};
  assign br_flags = flags_q;
  assign lr_we = state == S_UPDATE && opc == OPC_BL;
  assign lr_wdata = pc + 32'd1;
  assign busy = !(state == S_IDLE || state == S_HALT || state == S_FAULT);
  assign halted = state == S_HALT;
  assign fault = state == S_FAULT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized instruction streams against a per-instruction reference model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic imem_ack = 1'b0;
  logic alu_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_next = '0;
  logic [2:0] alu_flags = '0;
  logic imem_req, alu_start, lr_we, busy, halted, fault;
  logic [31:0] imem_addr, pc, br_dest, lr_wdata;
  logic [1:0] br_ctrl;
  logic [5:0] br_func;
  logic [2:0] br_flags;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc;
  logic [2:0] exp_flags;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h40), .FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_start(alu_start), .alu_valid(alu_valid), .alu_flags(alu_flags),
    .pc(pc), .pc_next(pc_next), .br_ctrl(br_ctrl), .br_func(br_func), .br_dest(br_dest),
    .br_flags(br_flags), .lr_we(lr_we), .lr_wdata(lr_wdata),
    .busy(busy), .halted(halted), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'b100: return 2'b00;
      3'b101: return 2'b01;
      3'b110: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    imem_ack = 1'b0;
    alu_valid = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h40);
    chk("rst_req", imem_req, 0);
    chk("rst_ctrl", br_ctrl, 2'b11);
    chk("rst_lr_wdata", lr_wdata, 32'h41);
    chk("rst_flags", br_flags, 0);
    chk("rst_outs", {busy, halted, fault, alu_start, lr_we}, 0);
    chk("rst_dest", br_dest, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = 32'h40;
    exp_flags = 3'b000;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // FETCH with flat wait cycles, then the DECODE cycle; returns at the negedge after DECODE
  task automatic fetch_decode(input logic [31:0] w, input int flat);
    for (int i = 0; i <= flat; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, exp_pc);
      chk("fetch_busy", busy, 1);
      imem_ack = (i == flat);
      imem_rdata = w;
      alu_valid = 1'($urandom);
      alu_flags = 3'($urandom);
      @(negedge clk);
    end
    alu_valid = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    chk("dec_req", imem_req, 0);
    chk("dec_func", br_func, {3'b000, w[28:26]});
    chk("dec_dest", br_dest, {6'b0, w[25:0]});
    chk("dec_flags", br_flags, exp_flags);
    if (w[31:30] != 2'b01 && w[31:29] != 3'b111) chk("dec_ctrl", br_ctrl, exp_ctrl(w[31:29]));
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic [31:0] nxt, input int flat,
                           input int alat, input logic [2:0] fl);
    fetch_decode(w, flat);
    if (w[31:30] == 2'b00) begin
      for (int j = 0; j <= alat; j++) begin
        chk("exec_start", alu_start, j == 0);
        alu_valid = (j == alat);
        alu_flags = (j == alat) ? fl : 3'($urandom);
        @(negedge clk);
      end
      alu_valid = 1'b0;
      exp_flags = fl;
    end
    chk("upd_ctrl", br_ctrl, exp_ctrl(w[31:29]));
    chk("upd_lr_we", lr_we, w[31:29] == 3'b110);
    chk("upd_lr_wdata", lr_wdata, exp_pc + 32'd1);
    pc_next = nxt;
    @(negedge clk);
    chk("upd_lr_we_drop", lr_we, 0);
    exp_pc = nxt;
    chk("new_pc", pc, exp_pc);
  endtask

  initial begin
    logic [31:0] w, nxt;
    logic [2:0] op;
    int k;
    do_reset();
    go();
    chk("first_addr", imem_addr, 32'h40);
    chk("first_req", imem_req, 1);
    run_instr({3'b000, 29'h123}, 32'h41, 0, 0, 3'b100);
    run_instr({3'b100, 3'b010, 26'h20}, 32'h20, 1, 0, 3'b000);
    chk("bz_pc", pc, 32'h20);
    run_instr({3'b001, 29'h7}, 32'h21, 2, 3, 3'b011);
    run_instr({3'b101, 3'b001, 26'h10}, 32'h10, 0, 0, 3'b000);
    run_instr({3'b110, 3'b000, 26'h1234}, 32'h1234, 0, 0, 3'b000);
    chk("bl_pc", pc, 32'h1234);
    run_instr({3'b100, 3'b000, 26'h5}, 32'h5, 0, 0, 3'b000);
    fetch_decode({3'b111, 29'h0}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("halt_flag", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_pc", pc, 32'h5);
      @(negedge clk);
    end
    go();
    exp_pc = 32'h6;
    chk("resume_addr", imem_addr, 32'h6);
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 4);
      op = k == 0 ? 3'b000 : k == 1 ? 3'b001 : k == 2 ? 3'b100 : k == 3 ? 3'b101 : 3'b110;
      w = {op, 29'($urandom)};
      nxt = op[2] ? $urandom : exp_pc + 32'd1;
      run_instr(w, nxt, $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom));
    end
    run_instr({3'b101, 29'h0}, 32'hFFFF_FFFF, 0, 0, 3'b000);
    start = 1'b1;
    fetch_decode({3'b111, 29'h0}, 0);
    chk("wrap_halt", halted, 1);
    @(negedge clk);
    start = 1'b0;
    exp_pc = 32'h0;
    chk("wrap_refetch_req", imem_req, 1);
    chk("wrap_refetch_addr", imem_addr, 32'h0);
    run_instr({3'b110, 29'h0}, 32'hFFFF_FFFF, 0, 0, 3'b000);
    start = 1'b1;
    fetch_decode({3'b110, 29'h0}, 0);
    start = 1'b0;
    chk("wrap_lr_wdata", lr_wdata, 32'h0);
    pc_next = 32'h100;
    @(negedge clk);
    exp_pc = 32'h100;
    // illegal opcode is terminal
    fetch_decode({3'b010, 29'h55}, 0);
    for (int i = 0; i < 5; i++) begin
      chk("ill_fault", fault, 1);
      chk("ill_busy", busy, 0);
      chk("ill_req", imem_req, 0);
      start = 1'b1;
      imem_ack = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    imem_ack = 1'b0;
    do_reset();
    go();
    #2 rst_n = 1'b0;
    #1 chk("async_req", imem_req, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("async_idle", busy, 0);
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
    go();
    for (int i = 0; i < 4; i++) begin
      chk("wdt_req", imem_req, 1);
      @(negedge clk);
    end
    chk("wdt_fault", fault, 1);
    chk("wdt_req_drop", imem_req, 0);
    do_reset();
    go();
    run_instr({3'b100, 29'h9}, 32'h9, 3, 0, 3'b000);
    chk("wdt_ack_wins", fault, 0);
`else
    go();
    for (int i = 0; i < 20; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_fault", fault, 0);
      @(negedge clk);
    end
    exp_pc = 32'h40;
    run_instr({3'b100, 29'h9}, 32'h9, 0, 0, 3'b000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
